// File: rtl/rotate_ctrl.sv
// rotate_ctrl: walks the 25 lanes of a 5x5x64 state once, reading each lane,
// rotating it left by its rho offset and writing it back in place.
// Lane order is row-major: for y = 0..4, x follows the external mod-5 counter.
// Optional build macro ROT_CHECK_EN adds a cnt_idx range check with a sticky
// idx_err output; without it the port and the check are absent.
module rotate_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        up_cnt,
  input  logic [2:0]  cnt_idx,
  output logic [4:0]  rd_addr,
  input  logic [63:0] rd_data,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [63:0] wr_data
`ifdef ROT_CHECK_EN
  ,
  output logic        idx_err
`endif
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd   = 2'd1,
    StWr   = 2'd2,
    StFin  = 2'd3
  } state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [2:0]  r_y;          // row counter
  logic [2:0]  r_lane;       // lanes completed within the current row
  logic [4:0]  r_addr;       // address issued in RD, reused for the write-back
  logic [2:0]  r_x;          // column index captured in RD
  logic [4:0]  w_rd_addr;
  logic        w_last_lane;
  logic        w_wr_ok;
  logic [5:0]  w_rho;

  // rho offset table indexed by {x, y}; octal literal digits read as x then y.
  function automatic logic [5:0] rho_lookup(input logic [2:0] x, input logic [2:0] y);
    logic [5:0] r;
    case ({x, y})
      6'o00: r = 6'd0;
      6'o01: r = 6'd36;
      6'o02: r = 6'd3;
      6'o03: r = 6'd41;
      6'o04: r = 6'd18;
      6'o10: r = 6'd1;
      6'o11: r = 6'd44;
      6'o12: r = 6'd10;
      6'o13: r = 6'd45;
      6'o14: r = 6'd2;
      6'o20: r = 6'd62;
      6'o21: r = 6'd6;
      6'o22: r = 6'd43;
      6'o23: r = 6'd15;
      6'o24: r = 6'd61;
      6'o30: r = 6'd28;
      6'o31: r = 6'd55;
      6'o32: r = 6'd25;
      6'o33: r = 6'd21;
      6'o34: r = 6'd56;
      6'o40: r = 6'd27;
      6'o41: r = 6'd20;
      6'o42: r = 6'd39;
      6'o43: r = 6'd8;
      6'o44: r = 6'd14;
      default: r = 6'd0;
    endcase
    return r;
  endfunction

  // Full circular left shift; a shift of 0 leaves the right-shift term at 0.
  function automatic logic [63:0] rotl64(input logic [63:0] d, input logic [5:0] r);
    return (d << r) | (d >> (7'd64 - {1'b0, r}));
  endfunction

  assign w_rd_addr   = ({2'b00, r_y} * 5'd5) + {2'b00, cnt_idx};
  assign w_last_lane = (r_lane == 3'd4) && (r_y == 3'd4);
  assign w_rho       = rho_lookup(r_x, r_y);

  // State register plus row/lane counters and the captured RD address/column.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_y     <= 3'd0;
      r_lane  <= 3'd0;
      r_addr  <= 5'd0;
      r_x     <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_y    <= 3'd0;
            r_lane <= 3'd0;
          end
        end
        StRd: begin
          r_addr <= w_rd_addr;
          r_x    <= cnt_idx;
        end
        StWr: begin
          if (r_lane == 3'd4) begin
            r_lane <= 3'd0;
            r_y    <= r_y + 3'd1;
          end else begin
            r_lane <= r_lane + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ROT_CHECK_EN
  logic r_idx_err;
  logic r_skip;

  // Range check on the column index: sticky error, and the offending lane is
  // suppressed at write-back while the pass keeps stepping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx_err <= 1'b0;
      r_skip    <= 1'b0;
    end else if (r_state == StRd) begin
      r_skip <= (cnt_idx > 3'd4);
      if (cnt_idx > 3'd4) begin
        r_idx_err <= 1'b1;
      end
    end
  end

  assign idx_err = r_idx_err;
  assign w_wr_ok = ~r_skip;
`else
  assign w_wr_ok = 1'b1;
`endif

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (start) w_state_nxt = StRd;
      StRd:    w_state_nxt = StWr;
      StWr:    w_state_nxt = w_last_lane ? StFin : StRd;
      StFin:   w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Output decode; every port is forced to 0 outside the state that uses it.
  always_comb begin
    busy    = (r_state != StIdle);
    done    = 1'b0;
    up_cnt  = 1'b0;
    rd_addr = 5'd0;
    wr_en   = 1'b0;
    wr_addr = 5'd0;
    wr_data = 64'd0;
    case (r_state)
      StRd: rd_addr = w_rd_addr;
      StWr: begin
        up_cnt  = 1'b1;
        wr_en   = w_wr_ok;
        wr_addr = r_addr;
        wr_data = rotl64(rd_data, w_rho);
      end
      StFin: done = 1'b1;
      default: ;
    endcase
  end

endmodule
